// File: rtl/sme_pkg.sv
// Shared definitions for the string-match engine: FSM encoding, default widths and
// ASCII case-fold constants.
package sme_pkg;

  localparam int MAX_PATTERN_DEF = 8;
  localparam int SYM_W_DEF       = 8;
  localparam int ADDR_W_DEF      = $clog2(MAX_PATTERN_DEF);

  localparam logic [7:0] ASCII_UPPER_A  = 8'h41;
  localparam logic [7:0] ASCII_UPPER_Z  = 8'h5A;
  localparam logic [7:0] ASCII_CASE_BIT = 8'h20;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_LOAD = 4'b0010,
    ST_CALC = 4'b0100,
    ST_DONE = 4'b1000
  } ff_state_t;

  // Maps 'A'..'Z' onto 'a'..'z'; every other code passes through unchanged.
  function automatic logic [7:0] ascii_fold(input logic [7:0] c);
    return ((c >= ASCII_UPPER_A) && (c <= ASCII_UPPER_Z)) ? (c | ASCII_CASE_BIT) : c;
  endfunction

endpackage

// File: rtl/kmp_sym_cmp.sv
// Combinational symbol equality for the failure-function engine.
// Build macro FF_NOCASE_EN: fold ASCII upper case to lower case before comparing (SYM_W = 8).
module kmp_sym_cmp
  import sme_pkg::*;
#(
  parameter int SYM_W = SYM_W_DEF
) (
  input  logic [SYM_W-1:0] sym_a,
  input  logic [SYM_W-1:0] sym_b,
  output logic             eq
);

`ifdef FF_NOCASE_EN
  assign eq = (ascii_fold(sym_a) == ascii_fold(sym_b));
`else
  assign eq = (sym_a == sym_b);
`endif

endmodule

// File: rtl/kmp_fail_table_gen.sv
// Sequential KMP prefix-table engine: one symbol compare per CALC cycle, with full fallback.
// Build macro FF_NOCASE_EN selects a case-insensitive ASCII compare inside kmp_sym_cmp.
module kmp_fail_table_gen
  import sme_pkg::*;
#(
  parameter int MAX_PATTERN = MAX_PATTERN_DEF,
  parameter int SYM_W       = SYM_W_DEF,
  parameter int ADDR_W      = $clog2(MAX_PATTERN),
  parameter int CNT_W       = 2*ADDR_W+1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_valid,
  input  logic [MAX_PATTERN*SYM_W-1:0]  pattern,
  input  logic [ADDR_W-1:0]             last_pat_idx,
  output logic [MAX_PATTERN*ADDR_W-1:0] o_fail_func,
  output logic                          o_valid,
  output logic                          o_busy,
  output logic [CNT_W-1:0]              o_cycles,
  output logic                          o_err
);

  ff_state_t state_q, state_d;

  logic [SYM_W-1:0]  pat_q  [MAX_PATTERN];
  logic [ADDR_W-1:0] fail_q [MAX_PATTERN];
  logic [ADDR_W-1:0] last_q, k_q, q_q;
  logic [CNT_W-1:0]  cycles_q;
  logic              err_q;

  logic [ADDR_W-1:0] last_clamped;
  logic [ADDR_W-1:0] k_m1;
  logic              last_oob;
  logic              sym_eq;
  logic              k_zero;
  logic              q_at_last;
  logic              step_done;

  assign last_oob     = ({1'b0, last_pat_idx} >= (ADDR_W+1)'(MAX_PATTERN));
  assign last_clamped = last_oob ? ADDR_W'(MAX_PATTERN-1) : last_pat_idx;

  assign k_m1      = k_q - 1'b1;
  assign k_zero    = (k_q == '0);
  assign q_at_last = (q_q == last_q);
  // q only resolves on a match or on a mismatch with nowhere left to fall back to.
  assign step_done = q_at_last && (sym_eq || k_zero);

  kmp_sym_cmp #(
    .SYM_W (SYM_W)
  ) u_sym_cmp (
    .sym_a (pat_q[k_q]),
    .sym_b (pat_q[q_q]),
    .eq    (sym_eq)
  );

  // NOTE: non-blocking assignments on every flop so all state updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every always_comb output takes a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    o_valid = 1'b0;
    o_busy  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_valid) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        o_busy = 1'b1;
        if (!i_valid)                state_d = ST_IDLE;
        else if (last_clamped == '0) state_d = ST_DONE;
        else                         state_d = ST_CALC;
      end
      ST_CALC: begin
        o_busy = 1'b1;
        if (!i_valid)      state_d = ST_IDLE;
        else if (step_done) state_d = ST_DONE;
      end
      ST_DONE: begin
        o_valid = 1'b1;
        if (!i_valid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: pattern storage has no reset; LOAD always rewrites it before CALC reads it.
  always_ff @(posedge clk) begin
    if (state_q == ST_LOAD) begin
      for (int j = 0; j < MAX_PATTERN; j++) begin
        pat_q[j] <= pattern[j*SYM_W +: SYM_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q   <= '0;
      k_q      <= '0;
      q_q      <= '0;
      cycles_q <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < MAX_PATTERN; i++) fail_q[i] <= '0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (i_valid) begin
            last_q   <= last_clamped;
            err_q    <= last_oob;
            k_q      <= '0;
            q_q      <= ADDR_W'(1);
            cycles_q <= '0;
            for (int i = 0; i < MAX_PATTERN; i++) fail_q[i] <= '0;
          end
        end
        ST_CALC: begin
          if (i_valid) begin
            cycles_q <= cycles_q + 1'b1;
            if (sym_eq) begin
              fail_q[q_q] <= k_q + 1'b1;
              k_q         <= k_q + 1'b1;
              if (!q_at_last) q_q <= q_q + 1'b1;
            end else if (!k_zero) begin
              // Fallback: retry the same q against the next shorter border.
              k_q <= fail_q[k_m1];
            end else begin
              fail_q[q_q] <= '0;
              if (!q_at_last) q_q <= q_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar gi = 0; gi < MAX_PATTERN; gi++) begin : g_table_out
    assign o_fail_func[gi*ADDR_W +: ADDR_W] = fail_q[gi];
  end

  assign o_cycles = cycles_q;
  assign o_err    = err_q;

endmodule

// File: tb/tb_kmp_fail_table_gen.sv
// Self-checking bench for kmp_fail_table_gen: directed cases plus random patterns scored
// against a brute-force border model.
module tb_kmp_fail_table_gen;

  // Six entries keep the index 3 bits wide, so an out-of-range last index can be driven.
  localparam int MAXP = 6;
  localparam int SW   = 8;
  localparam int AW   = $clog2(MAXP);
  localparam int CW   = 2*AW+1;

  typedef int ent_t [MAXP];

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 i_valid;
  logic [MAXP*SW-1:0]   pattern;
  logic [AW-1:0]        last_pat_idx;
  logic [MAXP*AW-1:0]   o_fail_func;
  logic                 o_valid;
  logic                 o_busy;
  logic [CW-1:0]        o_cycles;
  logic                 o_err;

  int n_checks = 0;
  int n_errors = 0;

  kmp_fail_table_gen #(
    .MAX_PATTERN (MAXP),
    .SYM_W       (SW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_valid      (i_valid),
    .pattern      (pattern),
    .last_pat_idx (last_pat_idx),
    .o_fail_func  (o_fail_func),
    .o_valid      (o_valid),
    .o_busy       (o_busy),
    .o_cycles     (o_cycles),
    .o_err        (o_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit sym_match(input logic [7:0] a, input logic [7:0] b);
`ifdef FF_NOCASE_EN
    if (a >= 8'h41 && a <= 8'h5A) a = a + 8'd32;
    if (b >= 8'h41 && b <= 8'h5A) b = b + 8'd32;
`endif
    return a == b;
  endfunction

  function automatic logic [MAXP*AW-1:0] tbl(input ent_t v);
    logic [MAXP*AW-1:0] t;
    for (int j = 0; j < MAXP; j++) t[j*AW +: AW] = AW'(v[j]);
    return t;
  endfunction

  // Unused tail symbols are random so the DUT must ignore everything past last.
  function automatic logic [MAXP*SW-1:0] pack_str(input string s);
    logic [MAXP*SW-1:0] p;
    for (int j = 0; j < MAXP; j++)
      p[j*SW +: SW] = (j < s.len()) ? s[j] : 8'($urandom_range(33, 126));
    return p;
  endfunction

  // Table by definition: longest proper prefix of P[0..q] that is also its suffix.
  // Cycle count: one compare per border tried while walking the border chain for each q.
  task automatic model(input logic [MAXP*SW-1:0] p, input int last,
                       output logic [MAXP*AW-1:0] t, output int cyc);
    int f [MAXP];
    logic [7:0] c [MAXP];
    bit ok;
    int k;
    for (int j = 0; j < MAXP; j++) begin
      c[j] = p[j*SW +: SW];
      f[j] = 0;
    end
    for (int q = 1; q <= last; q++) begin
      for (int len = 1; len <= q; len++) begin
        ok = 1'b1;
        for (int i = 0; i < len; i++)
          if (!sym_match(c[i], c[q-len+1+i])) ok = 1'b0;
        if (ok) f[q] = len;
      end
    end
    cyc = 0;
    for (int q = 1; q <= last; q++) begin
      k = f[q-1];
      forever begin
        cyc++;
        if (sym_match(c[k], c[q]) || k == 0) break;
        k = f[k-1];
      end
    end
    t = tbl(f);
  endtask

  task automatic run_job(input string name, input logic [MAXP*SW-1:0] p, input logic [AW-1:0] li,
                         input bit has_lit, input logic [MAXP*AW-1:0] lit_tbl, input int lit_cyc);
    logic [MAXP*AW-1:0] etbl;
    int  ecyc;
    int  last;
    int  lat;
    bit  exp_err;
    exp_err = (int'(li) >= MAXP);
    last    = exp_err ? MAXP-1 : int'(li);
    model(p, last, etbl, ecyc);

    @(negedge clk);
    pattern      = p;
    last_pat_idx = li;
    i_valid      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({name, "_load_busy"}, o_busy, 1'b1);
    check({name, "_load_valid"}, o_valid, 1'b0);
    lat = 1;
    while (!o_valid && lat < 40) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check({name, "_valid"}, o_valid, 1'b1);
    if (o_valid) begin
      check({name, "_table"}, o_fail_func, etbl);
      check({name, "_cycles"}, o_cycles, ecyc);
      check({name, "_err"}, o_err, exp_err);
      check({name, "_latency"}, lat, ecyc + 2);
      check({name, "_done_busy"}, o_busy, 1'b0);
      if (has_lit) begin
        check({name, "_table_lit"}, o_fail_func, lit_tbl);
        check({name, "_cycles_lit"}, o_cycles, lit_cyc);
      end
      repeat (2) @(negedge clk);
      check({name, "_hold_valid"}, o_valid, 1'b1);
      check({name, "_hold_cycles"}, o_cycles, ecyc);
      check({name, "_hold_table"}, o_fail_func, etbl);
    end
    i_valid = 1'b0;
    @(negedge clk);
    check({name, "_release_valid"}, o_valid, 1'b0);
  endtask

  task automatic abort_job(input string name, input bit use_reset);
    @(negedge clk);
    pattern      = pack_str("ABABAC");
    last_pat_idx = AW'(5);
    i_valid      = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check({name, "_mid_busy"}, o_busy, 1'b1);
    i_valid = 1'b0;
    if (use_reset) reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check({name, "_busy"}, o_busy, 1'b0);
    if (use_reset) begin
      check({name, "_table"}, o_fail_func, '0);
      check({name, "_cycles"}, o_cycles, 0);
    end
    repeat (3) begin
      @(negedge clk);
      check({name, "_valid"}, o_valid, 1'b0);
    end
  endtask

  initial begin
    logic [7:0] alpha [4];
    logic [MAXP*SW-1:0] rp;
    alpha[0] = "A"; alpha[1] = "B"; alpha[2] = "a"; alpha[3] = "b";

    reset        = 1'b1;
    i_valid      = 1'b0;
    pattern      = '0;
    last_pat_idx = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_valid", o_valid, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_cycles", o_cycles, 0);
    check("rst_err", o_err, 1'b0);
    check("rst_table", o_fail_func, '0);

    run_job("ababac", pack_str("ABABAC"), AW'(5), 1'b1, tbl('{0,0,1,2,3,0}), 7);
    run_job("aabaaa", pack_str("AABAAA"), AW'(5), 1'b1, tbl('{0,1,0,1,2,2}), 7);
    run_job("aaaa",   pack_str("AAAA"),   AW'(3), 1'b1, tbl('{0,1,2,3,0,0}), 3);
    run_job("last0",  pack_str("AAAA"),   AW'(0), 1'b1, tbl('{0,0,0,0,0,0}), 0);
    run_job("clamp",  pack_str("ABAABA"), AW'(MAXP+1), 1'b1, tbl('{0,0,1,1,2,3}), 6);
    run_job("legal",  pack_str("ABAB"),   AW'(3), 1'b1, tbl('{0,0,1,2,0,0}), 3);

    abort_job("drop", 1'b0);
    run_job("redo1", pack_str("ABABAC"), AW'(5), 1'b1, tbl('{0,0,1,2,3,0}), 7);
    abort_job("rst", 1'b1);
    run_job("redo2", pack_str("ABABAC"), AW'(5), 1'b1, tbl('{0,0,1,2,3,0}), 7);

`ifdef FF_NOCASE_EN
    run_job("case", pack_str("aBAb"), AW'(3), 1'b1, tbl('{0,0,1,2,0,0}), 3);
`else
    run_job("case", pack_str("aBAb"), AW'(3), 1'b1, tbl('{0,0,0,0,0,0}), 3);
`endif

    for (int n = 0; n < 30; n++) begin
      for (int j = 0; j < MAXP; j++) rp[j*SW +: SW] = alpha[$urandom_range(0, 3)];
      run_job($sformatf("rnd%0d", n), rp, AW'($urandom_range(0, 7)), 1'b0, '0, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
